// File: rtl/ysyx_22040383_regfile_pkg.sv
// Shared constants and types for the integer register file and its pending-write scoreboard.
// XLEN follows `YSYX_22040383_WIDTH; optional write-through bypass: YSYX_22040383_RF_BYPASS_EN.
`ifndef YSYX_22040383_WIDTH
`define YSYX_22040383_WIDTH 64
`endif

package ysyx_22040383_regfile_pkg;

  localparam int unsigned XLEN   = `YSYX_22040383_WIDTH;
  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned PEND_W = 2;

  localparam logic [AW-1:0]     REG_ZERO = 5'd0;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // One-hot register select; x0 never selects anything.
  function automatic logic [NREG-1:0] addr_onehot(input logic en, input logic [AW-1:0] addr);
    logic [NREG-1:0] onehot;
    onehot = '0;
    if (en && (addr != REG_ZERO)) onehot[addr] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/ysyx_22040383_regfile_scoreboard.sv
// Per-register pending-write counters: +1 on a legal rd issue, -1 on WB write, hold on both.
// Outputs per-register non-zero / exactly-one flags and the counter-full condition for rd.
module ysyx_22040383_scoreboard
  import ysyx_22040383_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_issue,
  input  logic            i_rd_wen,
  input  logic [AW-1:0]   i_rd_addr,
  input  logic            i_wb_wen,
  input  logic [AW-1:0]   i_wb_waddr,
  output logic [NREG-1:0] o_pend_nz,
  output logic [NREG-1:0] o_pend_one,
  output logic            o_full
);

  logic [PEND_W-1:0] r_pend [NREG];
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;

  assign w_inc = addr_onehot(i_issue && i_rd_wen, i_rd_addr);
  assign w_dec = addr_onehot(i_wb_wen, i_wb_waddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_pend[i] <= r_pend[i] + PEND_W'(1);
        end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - PEND_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_pend_nz  = '0;
    o_pend_one = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      o_pend_nz[i]  = (r_pend[i] != '0);
      o_pend_one[i] = (r_pend[i] == PEND_W'(1));
    end
  end

  assign o_full = i_rd_wen && (i_rd_addr != REG_ZERO) && (r_pend[i_rd_addr] == PEND_MAX);

`ifndef SYNTHESIS
  // A WB write with no matching issue means the pipeline lost track of an rd.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) ((w_dec & ~o_pend_nz) == '0));
`endif

endmodule

// File: rtl/ysyx_22040383_regfile.sv
// Integer register file: WB write port, two combinational ID read ports, RAW stall generation.
// Define YSYX_22040383_RF_BYPASS_EN to forward the same-cycle WB write to the read ports.
module ysyx_22040383_regfile
  import ysyx_22040383_regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_used,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs2_data,
  input  logic            id_issue,
  input  logic            id_rd_wen,
  input  logic [AW-1:0]   id_rd_addr,
  output logic            raw_stall,
  input  logic            wb_wen,
  input  logic [AW-1:0]   wb_waddr,
  input  logic [XLEN-1:0] wb_wdata
);

  wb_req_t         w_wb;
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] w_pend_nz;
  logic [NREG-1:0] w_pend_one;
  logic            w_full;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_haz1;
  logic            w_haz2;
  logic            w_issue_ok;

  assign w_wb = '{wen: wb_wen, addr: wb_waddr, data: wb_wdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (w_wb.wen && (w_wb.addr != REG_ZERO)) begin
      r_regs[w_wb.addr] <= w_wb.data;
    end
  end

`ifdef YSYX_22040383_RF_BYPASS_EN
  assign w_byp1 = w_wb.wen && (w_wb.addr == rs1_addr) && (rs1_addr != REG_ZERO);
  assign w_byp2 = w_wb.wen && (w_wb.addr == rs2_addr) && (rs2_addr != REG_ZERO);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    rs1_data = '0;
    if (w_byp1)                       rs1_data = w_wb.data;
    else if (rs1_addr != REG_ZERO)    rs1_data = r_regs[rs1_addr];
  end

  always_comb begin
    rs2_data = '0;
    if (w_byp2)                       rs2_data = w_wb.data;
    else if (rs2_addr != REG_ZERO)    rs2_data = r_regs[rs2_addr];
  end

  // A last outstanding write arriving this cycle is covered by the forward path.
  assign w_haz1 = rs1_used && (rs1_addr != REG_ZERO) && w_pend_nz[rs1_addr]
                  && !(w_pend_one[rs1_addr] && w_byp1);
  assign w_haz2 = rs2_used && (rs2_addr != REG_ZERO) && w_pend_nz[rs2_addr]
                  && !(w_pend_one[rs2_addr] && w_byp2);

  assign raw_stall  = w_haz1 || w_haz2 || w_full;
  assign w_issue_ok = id_issue && !raw_stall;

  ysyx_22040383_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_issue    (w_issue_ok),
    .i_rd_wen   (id_rd_wen),
    .i_rd_addr  (id_rd_addr),
    .i_wb_wen   (w_wb.wen),
    .i_wb_waddr (w_wb.addr),
    .o_pend_nz  (w_pend_nz),
    .o_pend_one (w_pend_one),
    .o_full     (w_full)
  );

`ifndef SYNTHESIS
  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst) !(id_issue && raw_stall));
`endif

endmodule

// File: tb/tb_ysyx_22040383_regfile.sv
// Directed self-checking bench for ysyx_22040383_regfile (both bypass configurations).
module tb_ysyx_22040383_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, id_rd_addr, wb_waddr;
  logic        rs1_used, rs2_used, id_issue, id_rd_wen, wb_wen;
  logic [63:0] rs1_data, rs2_data, wb_wdata;
  logic        raw_stall;

  int checks = 0;
  int errors = 0;
  logic byp;

  ysyx_22040383_regfile dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs1_used(rs1_used), .rs1_data(rs1_data),
    .rs2_addr(rs2_addr), .rs2_used(rs2_used), .rs2_data(rs2_data),
    .id_issue(id_issue), .id_rd_wen(id_rd_wen), .id_rd_addr(id_rd_addr),
    .raw_stall(raw_stall),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    checks++;
    if (raw_stall !== exp) begin
      errors++;
      $display("FAIL %s: raw_stall=%b expected %b", name, raw_stall, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: data=%h expected %h", name, act, exp);
    end
  endtask

  // Legal issue of one instruction writing rd (no sources read).
  task automatic issue_rd(input logic [4:0] rd);
    rs1_used = 1'b0; rs2_used = 1'b0;
    id_issue = 1'b1; id_rd_wen = 1'b1; id_rd_addr = rd;
    tick();
    id_issue = 1'b0; id_rd_wen = 1'b0; id_rd_addr = 5'd0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
    wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = '0;
  endtask

  task automatic test_reset();
    rs1_used = 1'b1; rs2_used = 1'b1;
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(r);
      #1;
      chk_data("reset_rs1", rs1_data, 64'h0);
      chk_data("reset_rs2", rs2_data, 64'h0);
    end
    chk_stall("reset_stall", 1'b0);
    rs1_used = 1'b0; rs2_used = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic test_write();
    issue_rd(5'd5);
    wb_write(5'd5, 64'hDEAD_BEEF);
    rs1_addr = 5'd5; rs1_used = 1'b1;
    #1;
    chk_data("write_x5", rs1_data, 64'hDEAD_BEEF);
    chk_stall("write_x5_nostall", 1'b0);
    wb_write(5'd0, 64'h1);
    rs2_addr = 5'd0; rs2_used = 1'b1; rs1_addr = 5'd0;
    #1;
    chk_data("write_x0_rs2", rs2_data, 64'h0);
    chk_data("write_x0_rs1", rs1_data, 64'h0);
    rs1_used = 1'b0; rs2_used = 1'b0;
  endtask

  task automatic test_hazard();
    issue_rd(5'd7);
    rs2_addr = 5'd7; rs2_used = 1'b1;
    #1;
    chk_stall("haz_rs2_used", 1'b1);
    rs2_used = 1'b0;
    #1;
    chk_stall("haz_rs2_unused", 1'b0);
    rs2_used = 1'b1;
    wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 64'h77;
    #1;
    chk_stall("haz_same_cycle_wb", byp ? 1'b0 : 1'b1);
    tick();
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = '0;
    #1;
    chk_stall("haz_cleared", 1'b0);
    chk_data("haz_x7_value", rs2_data, 64'h77);
    rs2_used = 1'b0; rs2_addr = 5'd0;
  endtask

  task automatic test_pending();
    issue_rd(5'd3);
    id_issue = 1'b1; id_rd_wen = 1'b1; id_rd_addr = 5'd3;
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 64'h33;
    tick();
    id_issue = 1'b0; id_rd_wen = 1'b0; id_rd_addr = 5'd0;
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = '0;
    rs1_addr = 5'd3; rs1_used = 1'b1;
    #1;
    chk_stall("pend3_held", 1'b1);
    wb_write(5'd3, 64'h34);
    #1;
    chk_stall("pend3_cleared", 1'b0);
    chk_data("pend3_value", rs1_data, 64'h34);
    rs1_used = 1'b0; rs1_addr = 5'd0;
    for (int k = 0; k < 3; k++) begin
      id_rd_wen = 1'b1; id_rd_addr = 5'd9;
      #1;
      chk_stall("pend9_not_full", 1'b0);
      issue_rd(5'd9);
    end
    id_rd_wen = 1'b1; id_rd_addr = 5'd9;
    #1;
    chk_stall("pend9_full", 1'b1);
    id_rd_addr = 5'd8;
    #1;
    chk_stall("pend8_not_full", 1'b0);
    id_rd_wen = 1'b0; id_rd_addr = 5'd0;
    for (int k = 0; k < 3; k++) wb_write(5'd9, 64'(k + 90));
    rs1_addr = 5'd9; rs1_used = 1'b1;
    #1;
    chk_stall("pend9_drained", 1'b0);
    chk_data("pend9_value", rs1_data, 64'd92);
    rs1_used = 1'b0; rs1_addr = 5'd0;
  endtask

  task automatic test_bypass();
    issue_rd(5'd4);
    rs1_addr = 5'd4; rs1_used = 1'b1;
    wb_wen = 1'b1; wb_waddr = 5'd4; wb_wdata = 64'h55;
    #1;
    chk_data("byp_rs1_data", rs1_data, byp ? 64'h55 : 64'h0);
    chk_stall("byp_stall", byp ? 1'b0 : 1'b1);
    tick();
    wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = '0;
    #1;
    chk_data("byp_after_data", rs1_data, 64'h55);
    chk_stall("byp_after_stall", 1'b0);
    rs1_used = 1'b0; rs1_addr = 5'd0;
  endtask

  task automatic test_reset_mid();
    issue_rd(5'd10);
    issue_rd(5'd10);
    issue_rd(5'd10);
    wb_write(5'd10, 64'h7);
    rs1_addr = 5'd10; rs1_used = 1'b1;
    #1;
    chk_data("mid_x10_before", rs1_data, 64'h7);
    chk_stall("mid_stall_before", 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_data("mid_x10_reset", rs1_data, 64'h0);
    chk_stall("mid_stall_reset", 1'b0);
    tick();
    rst = 1'b0;
    tick();
    id_rd_wen = 1'b1; id_rd_addr = 5'd10;
    #1;
    chk_stall("mid_after_release", 1'b0);
    id_rd_wen = 1'b0; id_rd_addr = 5'd0; rs1_used = 1'b0; rs1_addr = 5'd0;
  endtask

  initial begin
`ifdef YSYX_22040383_RF_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    rst = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0; id_rd_addr = 5'd0; wb_waddr = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; id_issue = 1'b0; id_rd_wen = 1'b0; wb_wen = 1'b0;
    wb_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_write();
    test_hazard();
    test_pending();
    test_bypass();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
